// File: rtl/axis_packet_arb.sv
// Packet-granular round-robin arbiter: S_COUNT AXI-Stream sources share one output, grant held
// until the granted source's tlast is accepted. Define AXIS_PKT_ARB_OUT_REG_EN for a skid output.
module axis_packet_arb #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  localparam int unsigned IW        = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [S_COUNT-1:0]             s_axis_tvalid,
  output logic [S_COUNT-1:0]             s_axis_tready,
  input  logic [S_COUNT-1:0]             s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]    s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]  s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic [DEST_WIDTH-1:0]          m_axis_tdest,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic                           grant_valid,
  output logic [IW-1:0]                  grant_index
);

  localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  typedef enum logic {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d, last_q, last_d, pick;
  logic            pick_valid, active, sel_valid, port_ready, xfer, out_valid;
  logic [PW-1:0]   pay [S_COUNT];
  logic [PW-1:0]   sel_pay, out_pay;

  // Payload bundle {data, keep, id, dest, user, last}; last sits in bit 0.
  for (genvar i = 0; i < S_COUNT; i++) begin : g_pay
    assign pay[i] = {s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH], s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH],
                     s_axis_tid[i*ID_WIDTH +: ID_WIDTH], s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH],
                     s_axis_tuser[i*USER_WIDTH +: USER_WIDTH], s_axis_tlast[i]};
  end

  assign active    = (state_q == StActive);
  assign sel_pay   = pay[grant_q];
  assign sel_valid = s_axis_tvalid[grant_q];
  assign xfer      = active & sel_valid & port_ready;

  // Scan downward so the requester nearest to last_grant+1 is the one left in pick.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned k = S_COUNT; k >= 1; k--) begin
      if (s_axis_tvalid[IW'((32'(last_q) + k) % S_COUNT)]) begin
        pick       = IW'((32'(last_q) + k) % S_COUNT);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = StActive;
        end
      end
      StActive: begin
        if (xfer && sel_pay[0]) begin
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IW'(S_COUNT - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_axis_tready = '0;
    if (active) s_axis_tready[grant_q] = port_ready;
  end

`ifdef AXIS_PKT_ARB_OUT_REG_EN
  logic [PW-1:0] out_q, skid_q;
  logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic          load_out_in, load_out_skid, load_skid;

  // Source is ready whenever the skid entry is empty, which is itself a register.
  assign port_ready = ~skid_valid_q;

  always_comb begin
    out_valid_d   = out_valid_q;
    skid_valid_d  = skid_valid_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (!skid_valid_q) begin
      if (m_axis_tready || !out_valid_q) begin
        out_valid_d = xfer;
        load_out_in = xfer;
      end else if (xfer) begin
        skid_valid_d = 1'b1;
        load_skid    = 1'b1;
      end
    end else if (m_axis_tready) begin
      out_valid_d   = 1'b1;
      skid_valid_d  = 1'b0;
      load_out_skid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      if (load_out_in)   out_q  <= sel_pay;
      if (load_out_skid) out_q  <= skid_q;
      if (load_skid)     skid_q <= sel_pay;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pay   = out_q;
`else
  assign port_ready = m_axis_tready;
  assign out_valid  = active & sel_valid;
  assign out_pay    = {sel_pay[PW-1:1], active & sel_pay[0]};
`endif

  assign m_axis_tvalid = out_valid;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tdest, m_axis_tuser, m_axis_tlast} = out_pay;
  assign grant_valid   = active;
  assign grant_index   = grant_q;

endmodule

// File: tb/tb_axis_packet_arb.sv
// Randomized bench for axis_packet_arb against a packet-level round-robin reference model.
module tb_axis_packet_arb;
  localparam int S  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int GW = 2;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic        user;
    logic        last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [S-1:0][DW-1:0] s_tdata;
  logic [S-1:0][KW-1:0] s_tkeep;
  logic [S-1:0][7:0]    s_tid, s_tdest;
  logic [S-1:0]         s_tuser, s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]        m_tdata;
  logic [KW-1:0]        m_tkeep;
  logic [7:0]           m_tid, m_tdest;
  logic                 m_tuser, m_tvalid, m_tready, m_tlast, grant_valid;
  logic [GW-1:0]        grant_index;

  always #5 clk = ~clk;

  axis_packet_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8), .DEST_WIDTH(8),
                    .USER_WIDTH(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  beat_t srcq [S][$];
  beat_t expq [$];
  int    n_chk = 0, n_fail = 0;
  int    owner = -1, last_g = S - 1;
  int    pause [S];
  int    rate = 100, rdy_mode = 0;
  bit    prev_stall = 0;
  beat_t prev_beat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int port, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = {$urandom, $urandom};
      b.keep = 8'($urandom);
      b.id   = 8'($urandom);
      b.dest = 8'($urandom);
      b.user = 1'($urandom);
      b.last = (j == len - 1);
      srcq[port].push_back(b);
    end
  endtask

  // Sources keep tvalid asserted until accepted; new beats are offered at random.
  task automatic drive();
    for (int i = 0; i < S; i++) begin
      if (srcq[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
      end else begin
        s_tdata[i] = srcq[i][0].data;
        s_tkeep[i] = srcq[i][0].keep;
        s_tid[i]   = srcq[i][0].id;
        s_tdest[i] = srcq[i][0].dest;
        s_tuser[i] = srcq[i][0].user;
        s_tlast[i] = srcq[i][0].last;
        if (pause[i] > 0) begin
          pause[i]--;
          s_tvalid[i] = 1'b0;
        end else if (!s_tvalid[i]) begin
          s_tvalid[i] = ($urandom_range(99) < rate);
        end
      end
    end
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic step();
    logic [S-1:0] acc, exp_rdy;
    logic         exp_v;
    int           nxt;
    beat_t        b;
    @(negedge clk);
    acc = '0; exp_rdy = '0; exp_v = 1'b0; nxt = owner;
    chk("grant_valid", grant_valid, owner >= 0);
    if (owner >= 0) begin
      chk("grant_index", grant_index, owner);
      exp_rdy[owner] = m_tready;
      exp_v          = s_tvalid[owner];
`ifdef AXIS_PKT_ARB_OUT_REG_EN
      acc[owner] = s_tvalid[owner] && s_tready[owner];
`else
      acc[owner] = s_tvalid[owner] && m_tready;
`endif
      if (acc[owner]) begin
        expq.push_back(srcq[owner][0]);
        if (srcq[owner][0].last) begin
          last_g = owner;
          nxt    = -1;
        end
      end
    end else begin
      for (int k = 1; k <= S; k++)
        if (nxt < 0 && s_tvalid[(last_g + k) % S]) nxt = (last_g + k) % S;
    end
`ifndef AXIS_PKT_ARB_OUT_REG_EN
    chk("s_tready", s_tready, exp_rdy);
    chk("m_tvalid", m_tvalid, exp_v);
`endif
    if (prev_stall) begin
      chk("stall_tvalid", m_tvalid, 1);
      chk("stall_tdata", m_tdata, prev_beat.data);
      chk("stall_tid", m_tid, prev_beat.id);
      chk("stall_tdest", m_tdest, prev_beat.dest);
      chk("stall_tuser", m_tuser, prev_beat.user);
    end
    if (m_tvalid && m_tready) begin
      chk("beat_expected", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        b = expq.pop_front();
        chk("m_tdata", m_tdata, b.data);
        chk("m_tkeep", m_tkeep, b.keep);
        chk("m_tid", m_tid, b.id);
        chk("m_tdest", m_tdest, b.dest);
        chk("m_tuser", m_tuser, b.user);
        chk("m_tlast", m_tlast, b.last);
      end
    end
    prev_stall     = m_tvalid && !m_tready;
    prev_beat.data = m_tdata;
    prev_beat.id   = m_tid;
    prev_beat.dest = m_tdest;
    prev_beat.user = m_tuser;
    @(posedge clk);
    #1;
    owner = nxt;
    for (int i = 0; i < S; i++)
      if (acc[i]) begin
        void'(srcq[i].pop_front());
        s_tvalid[i] = 1'b0;
      end
    drive();
  endtask

  function automatic bit busy();
    busy = (owner >= 0) || (expq.size() > 0);
    for (int i = 0; i < S; i++) if (srcq[i].size() > 0) busy = 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_index", grant_index, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst        = 1'b0;
    owner      = -1;
    last_g     = S - 1;
    prev_stall = 1'b0;
    expq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_tvalid = '0; m_tready = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tid = '0; s_tdest = '0; s_tuser = '0; s_tlast = '0;
    for (int i = 0; i < S; i++) pause[i] = 0;
    do_reset();

    // Single 3-beat packet from port 0 at full rate.
    add_pkt(0, 3);
    drive();
    drain(50);

    // Ports 0..2 each offering two 2-beat packets; round robin from port 0 after reset.
    do_reset();
    for (int r = 0; r < 2; r++) for (int p = 0; p < 3; p++) add_pkt(p, 2);
    drive();
    drain(100);

    // Port 1 stalls 5 cycles mid-packet while port 3 waits.
    add_pkt(1, 4);
    drive();
    step();
    pause[1] = 5;
    add_pkt(3, 2);
    step();
    drain(100);

    // Output back-pressure toggling during a 4-beat packet.
    rdy_mode = 1;
    add_pkt(0, 4);
    drive();
    drain(100);
    rdy_mode = 0;

    // Reset during beat 2 of a port 2 packet, port 0 requesting.
    add_pkt(2, 4);
    drive();
    step();
    step();
    add_pkt(0, 2);
    drive();
    do_reset();
    drain(100);

    // Random traffic and back-pressure.
    rdy_mode = 2;
    for (int ph = 0; ph < 4; ph++) begin
      rate = 30 + 20 * ph;
      repeat (150) begin
        if ($urandom_range(5) == 0) add_pkt($urandom_range(S - 1), 1 + $urandom_range(4));
        step();
      end
    end
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
